// File: rtl/axi_slave_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_slave_pkg                                                |
// | Description : Shared widths, FSM states and AXI encodings for the SRAM      |
// |               responder and its beat/address generator.                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package axi_slave_pkg;

  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_SIZE_BITS = 3;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_STRB_BITS = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WDATA = 3'd3,
    S_BRESP = 3'd4
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/axi_beat_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_beat_addr_gen                                            |
// | Description : Word address and beat counter for one burst, shared by the   |
// |               read and write paths.                                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module axi_beat_addr_gen
  import axi_slave_pkg::*;
#(
  parameter int SRAM_AW = 14,
  parameter int LEN_W   = AXI_LEN_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [SRAM_AW-1:0] i_addr,
  input  logic [LEN_W-1:0]   i_len,
  input  logic [1:0]         i_burst,
  input  logic               i_advance,
  output logic [SRAM_AW-1:0] o_addr,
  output logic               o_last
);

  logic [SRAM_AW-1:0] r_addr;
  logic [LEN_W-1:0]   r_beat;
  logic [LEN_W-1:0]   r_len;
  logic [1:0]         r_burst;
  logic [SRAM_AW-1:0] w_next_addr;

  // WRAP is treated as a plain increment; the natural 2^SRAM_AW rollover is kept.
  always_comb begin
    w_next_addr = r_addr;
    case (r_burst)
      BURST_FIXED: w_next_addr = r_addr;
      BURST_INCR:  w_next_addr = r_addr + SRAM_AW'(1);
      BURST_WRAP:  w_next_addr = r_addr + SRAM_AW'(1);
      default:     w_next_addr = r_addr + SRAM_AW'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_beat  <= '0;
      r_len   <= '0;
      r_burst <= BURST_FIXED;
    end else if (i_load) begin
      r_addr  <= i_addr;
      r_beat  <= '0;
      r_len   <= i_len;
      r_burst <= i_burst;
    end else if (i_advance) begin
      r_addr  <= w_next_addr;
      r_beat  <= r_beat + LEN_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_beat == r_len);

endmodule
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_sram_slave                                               |
// | Description : Single-transaction AXI4 responder driving a single-port      |
// |               synchronous SRAM macro.                                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module axi_sram_slave
  import axi_slave_pkg::*;
#(
  parameter int SRAM_AW = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AXI_IDS_BITS-1:0]  ARID,
  input  logic [AXI_ADDR_BITS-1:0] ARADDR,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN,
  input  logic [AXI_SIZE_BITS-1:0] ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [AXI_IDS_BITS-1:0]  RID,
  output logic [AXI_DATA_BITS-1:0] RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  input  logic [AXI_IDS_BITS-1:0]  AWID,
  input  logic [AXI_ADDR_BITS-1:0] AWADDR,
  input  logic [AXI_LEN_BITS-1:0]  AWLEN,
  input  logic [AXI_SIZE_BITS-1:0] AWSIZE,
  input  logic [1:0]               AWBURST,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [AXI_DATA_BITS-1:0] WDATA,
  input  logic [AXI_STRB_BITS-1:0] WSTRB,
  input  logic                     WLAST,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [AXI_IDS_BITS-1:0]  BID,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  output logic                     sram_cs,
  output logic                     sram_oe,
  output logic [3:0]               sram_web,
  output logic [SRAM_AW-1:0]       sram_a,
  output logic [31:0]              sram_di,
  input  logic [31:0]              sram_do
);

  state_t                   r_state;
  state_t                   w_next;
  logic [AXI_IDS_BITS-1:0]  r_id;
  logic [1:0]               r_bresp;
  logic                     r_wlast_early;
  logic [AXI_DATA_BITS-1:0] r_rdata;
  logic                     r_rd_fresh;

  logic                     w_ar_hs;
  logic                     w_aw_hs;
  logic                     w_w_hs;
  logic                     w_load;
  logic                     w_advance;
  logic                     w_last;
  logic [SRAM_AW-1:0]       w_beat_addr;
  logic [SRAM_AW-1:0]       w_load_addr;
  logic [AXI_LEN_BITS-1:0]  w_load_len;
  logic [1:0]               w_load_burst;
  logic                     w_unused_bits;

  assign w_ar_hs      = ARVALID & ARREADY;
  assign w_aw_hs      = AWVALID & AWREADY;
  assign w_w_hs       = WVALID & WREADY;
  assign w_load       = w_ar_hs | w_aw_hs;
  assign w_load_addr  = w_aw_hs ? AWADDR[SRAM_AW+1:2] : ARADDR[SRAM_AW+1:2];
  assign w_load_len   = w_aw_hs ? AWLEN : ARLEN;
  assign w_load_burst = w_aw_hs ? AWBURST : ARBURST;

  // Size is always a full word and upper address bits are decoded upstream.
  assign w_unused_bits = ^{ARSIZE, AWSIZE,
                           ARADDR[AXI_ADDR_BITS-1:SRAM_AW+2], ARADDR[1:0],
                           AWADDR[AXI_ADDR_BITS-1:SRAM_AW+2], AWADDR[1:0]};

  axi_beat_addr_gen #(
    .SRAM_AW (SRAM_AW),
    .LEN_W   (AXI_LEN_BITS)
  ) u_beat_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_addr    (w_load_addr),
    .i_len     (w_load_len),
    .i_burst   (w_load_burst),
    .i_advance (w_advance),
    .o_addr    (w_beat_addr),
    .o_last    (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Every handshake and SRAM strobe is masked while rst is high.
  always_comb begin
    w_next    = r_state;
    ARREADY   = 1'b0;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    RVALID    = 1'b0;
    RLAST     = 1'b0;
    BVALID    = 1'b0;
    sram_cs   = 1'b0;
    sram_oe   = 1'b0;
    sram_web  = 4'hF;
    sram_a    = '0;
    sram_di   = '0;
    w_advance = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          AWREADY = AWVALID;
          ARREADY = ARVALID & ~AWVALID;
          if (AWVALID) begin
            w_next = S_WDATA;
          end else if (ARVALID) begin
            w_next = S_RADDR;
          end
        end
        S_RADDR: begin
          sram_cs = 1'b1;
          sram_oe = 1'b1;
          sram_a  = w_beat_addr;
          w_next  = S_RDATA;
        end
        S_RDATA: begin
          RVALID = 1'b1;
          RLAST  = w_last;
          if (RREADY) begin
            w_advance = ~w_last;
            w_next    = w_last ? S_IDLE : S_RADDR;
          end
        end
        S_WDATA: begin
          WREADY = 1'b1;
          if (WVALID) begin
            sram_cs   = 1'b1;
            sram_web  = ~WSTRB;
            sram_di   = WDATA;
            sram_a    = w_beat_addr;
            w_advance = ~w_last;
            if (w_last) begin
              w_next = S_BRESP;
            end
          end
        end
        S_BRESP: begin
          BVALID = 1'b1;
          if (BREADY) begin
            w_next = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // The macro presents data one cycle after the read strobe: pass it straight
  // through on the first RDATA cycle, then hold the captured copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id          <= '0;
      r_bresp       <= RESP_OKAY;
      r_wlast_early <= 1'b0;
      r_rdata       <= '0;
      r_rd_fresh    <= 1'b0;
    end else begin
      r_rd_fresh <= (r_state == S_RADDR);
      if (r_rd_fresh) begin
        r_rdata <= sram_do;
      end
      if (w_load) begin
        r_id <= w_aw_hs ? AWID : ARID;
      end
      if (w_aw_hs) begin
        r_wlast_early <= 1'b0;
      end
      if (w_w_hs) begin
        if (!w_last && WLAST) begin
          r_wlast_early <= 1'b1;
        end
        if (w_last) begin
          r_bresp <= (WLAST && !r_wlast_early) ? RESP_OKAY : RESP_SLVERR;
        end
      end
    end
  end

  assign RDATA = RVALID ? (r_rd_fresh ? sram_do : r_rdata) : '0;
  assign RID   = RVALID ? r_id : '0;
  assign RRESP = RESP_OKAY;
  assign BID   = BVALID ? r_id : '0;
  assign BRESP = BVALID ? r_bresp : RESP_OKAY;

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axi_sram_slave                                            |
// | Description : Directed bench for axi_sram_slave with a behavioural SRAM.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_axi_sram_slave;
  import axi_slave_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  ARID, AWID, RID, BID;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [3:0]  ARLEN, AWLEN, WSTRB;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        sram_cs, sram_oe;
  logic [3:0]  sram_web;
  logic [13:0] sram_a;
  logic [31:0] sram_di, sram_do;

  int checks = 0;
  int errors = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd [16];
  logic        rl [16];
  logic [1:0]  rr [16];
  logic [7:0]  rid_seen [16];
  int          rd_lat;
  logic [1:0]  b_resp;
  logic [7:0]  b_id;

  // Behavioural SRAM plus a backdoor preload port owned by the same process.
  logic [31:0] mem [0:16383];
  logic        pre_en = 1'b0;
  logic [13:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (sram_cs) begin
      if (sram_oe) sram_do <= mem[sram_a];
      for (int b = 0; b < 4; b++)
        if (!sram_web[b]) mem[sram_a][b*8 +: 8] <= sram_di[b*8 +: 8];
    end
  end

  axi_sram_slave #(.SRAM_AW(14)) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web), .sram_a(sram_a),
    .sram_di(sram_di), .sram_do(sram_do)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic idle_inputs();
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = BURST_INCR; ARVALID = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = BURST_INCR; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; RREADY = 1'b0; BREADY = 1'b0;
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [3:0] len,
                            input logic [7:0] id, input logic [1:0] burst);
    int n;
    ARADDR = addr; ARLEN = len; ARID = id; ARBURST = burst; ARVALID = 1'b1; RREADY = 1'b1;
    #1;
    n = 0;
    while (!ARREADY && n < 20) begin tick(); n++; end
    if (!ARREADY) begin
      checks++; errors++;
      $display("FAIL ar_handshake_timeout: ARREADY=%0b required 1", ARREADY);
      ARVALID = 1'b0; RREADY = 1'b0;
      return;
    end
    tick();
    ARVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      n = 1;
      while (!RVALID && n < 20) begin tick(); n++; end
      if (!RVALID) begin
        checks++; errors++;
        $display("FAIL rvalid_timeout beat %0d: RVALID=%0b required 1", i, RVALID);
        RREADY = 1'b0;
        return;
      end
      if (i == 0) rd_lat = n;
      rd[i] = RDATA; rl[i] = RLAST; rr[i] = RRESP; rid_seen[i] = RID;
      tick();
    end
    RREADY = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] len,
                             input logic [7:0] id, input logic [1:0] burst, input int wlast_beat);
    int n;
    AWADDR = addr; AWLEN = len; AWID = id; AWBURST = burst; AWVALID = 1'b1;
    #1;
    n = 0;
    while (!AWREADY && n < 20) begin tick(); n++; end
    if (!AWREADY) begin
      checks++; errors++;
      $display("FAIL aw_handshake_timeout: AWREADY=%0b required 1", AWREADY);
      AWVALID = 1'b0;
      return;
    end
    tick();
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == wlast_beat); WVALID = 1'b1;
      #1;
      n = 0;
      while (!WREADY && n < 20) begin tick(); n++; end
      if (!WREADY) begin
        checks++; errors++;
        $display("FAIL wready_timeout beat %0d: WREADY=%0b required 1", i, WREADY);
        WVALID = 1'b0; WLAST = 1'b0;
        return;
      end
      tick();
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    #1;
    n = 0;
    while (!BVALID && n < 20) begin tick(); n++; end
    if (!BVALID) begin
      checks++; errors++;
      $display("FAIL bvalid_timeout: BVALID=%0b required 1", BVALID);
      BREADY = 1'b0;
      return;
    end
    b_resp = BRESP; b_id = BID;
    tick();
    BREADY = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick(); tick();
    ARVALID = 1'b1;
    #1;
    checks++; if (ARREADY !== 1'b0) begin errors++; $display("FAIL reset_arready: got %0b want 0", ARREADY); end
    checks++; if (sram_web !== 4'hF) begin errors++; $display("FAIL reset_web: got %h want F", sram_web); end
    checks++; if ({sram_cs, sram_oe, RVALID, BVALID, WREADY, AWREADY} !== 6'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b want 000000", {sram_cs, sram_oe, RVALID, BVALID, WREADY, AWREADY}); end
    checks++; if (RDATA !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", RDATA); end
    ARVALID = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    preload(14'h10, 32'hDEADBEEF);
    read_burst(32'h40, 4'd0, 8'h23, BURST_INCR);
    checks++; if (rd_lat != 2) begin errors++; $display("FAIL single_latency: got %0d want 2", rd_lat); end
    checks++; if (rd[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h want DEADBEEF", rd[0]); end
    checks++; if (rl[0] !== 1'b1) begin errors++; $display("FAIL single_rlast: got %0b want 1", rl[0]); end
    checks++; if (rid_seen[0] !== 8'h23) begin errors++; $display("FAIL single_rid: got %h want 23", rid_seen[0]); end
    checks++; if (rr[0] !== 2'b00) begin errors++; $display("FAIL single_rresp: got %b want 00", rr[0]); end
  endtask

  task automatic test_burst_write_read();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    write_burst(32'h100, 4'd3, 8'h5A, BURST_INCR, 3);
    checks++; if (b_resp !== 2'b00) begin errors++; $display("FAIL burst_bresp: got %b want 00", b_resp); end
    checks++; if (b_id !== 8'h5A) begin errors++; $display("FAIL burst_bid: got %h want 5A", b_id); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[14'h40 + 14'(i)] !== 32'(i + 1))
        begin errors++; $display("FAIL burst_mem[%0d]: got %h want %h", i, mem[14'h40 + 14'(i)], 32'(i + 1)); end
    end
    read_burst(32'h100, 4'd3, 8'h11, BURST_INCR);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd[i] !== 32'(i + 1) || rl[i] !== (i == 3) || rid_seen[i] !== 8'h11)
        begin errors++; $display("FAIL burst_read beat %0d: data %h last %0b id %h want %h %0b 11",
                                 i, rd[i], rl[i], rid_seen[i], 32'(i + 1), (i == 3)); end
    end
  endtask

  task automatic test_strobe_backpressure();
    int n;
    logic [31:0] first;
    preload(14'h200, 32'h11111111);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    write_burst(32'h800, 4'd0, 8'h01, BURST_INCR, 0);
    checks++; if (mem[14'h200] !== 32'h11BB11DD) begin errors++; $display("FAIL strobe_mem: got %h want 11BB11DD", mem[14'h200]); end
    ARADDR = 32'h800; ARLEN = 4'd0; ARID = 8'h02; ARBURST = BURST_INCR; ARVALID = 1'b1; RREADY = 1'b0;
    #1;
    n = 0;
    while (!ARREADY && n < 20) begin tick(); n++; end
    tick();
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < 20) begin tick(); n++; end
    first = RDATA;
    checks++; if (first !== 32'h11BB11DD) begin errors++; $display("FAIL strobe_read: got %h want 11BB11DD", first); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (RVALID !== 1'b1 || RDATA !== 32'h11BB11DD)
        begin errors++; $display("FAIL hold_cycle %0d: RVALID %0b RDATA %h want 1 11BB11DD", k, RVALID, RDATA); end
    end
    RREADY = 1'b1;
    #1;
    tick();
    RREADY = 1'b0;
    checks++; if (RVALID !== 1'b0) begin errors++; $display("FAIL hold_release: RVALID %0b want 0", RVALID); end
  endtask

  task automatic test_simultaneous();
    int n;
    AWADDR = 32'h300; AWLEN = 4'd0; AWID = 8'h77; AWBURST = BURST_INCR; AWVALID = 1'b1;
    ARADDR = 32'h40;  ARLEN = 4'd0; ARID = 8'h44; ARBURST = BURST_INCR; ARVALID = 1'b1;
    #1;
    checks++; if (AWREADY !== 1'b1) begin errors++; $display("FAIL simul_awready: got %0b want 1", AWREADY); end
    checks++; if (ARREADY !== 1'b0) begin errors++; $display("FAIL simul_arready: got %0b want 0", ARREADY); end
    tick();
    AWVALID = 1'b0;
    #1;
    checks++; if (ARREADY !== 1'b0) begin errors++; $display("FAIL simul_arready_wdata: got %0b want 0", ARREADY); end
    WDATA = 32'h12345678; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    #1;
    tick();
    WVALID = 1'b0; WLAST = 1'b0;
    #1;
    checks++; if (BVALID !== 1'b1 || ARREADY !== 1'b0)
      begin errors++; $display("FAIL simul_bresp_phase: BVALID %0b ARREADY %0b want 1 0", BVALID, ARREADY); end
    BREADY = 1'b1;
    #1;
    tick();
    BREADY = 1'b0;
    #1;
    checks++; if (ARREADY !== 1'b1) begin errors++; $display("FAIL simul_arready_after_b: got %0b want 1", ARREADY); end
    RREADY = 1'b1;
    tick();
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < 20) begin tick(); n++; end
    checks++; if (RDATA !== 32'hDEADBEEF || RID !== 8'h44)
      begin errors++; $display("FAIL simul_read: RDATA %h RID %h want DEADBEEF 44", RDATA, RID); end
    tick();
    RREADY = 1'b0;
    checks++; if (mem[14'hC0] !== 32'h12345678) begin errors++; $display("FAIL simul_mem: got %h want 12345678", mem[14'hC0]); end
  endtask

  task automatic test_protocol_error_and_wrap();
    wd[0] = 32'hA0; wd[1] = 32'hA1; ws[0] = 4'hF; ws[1] = 4'hF;
    write_burst(32'h400, 4'd1, 8'h31, BURST_INCR, 0);
    checks++; if (b_resp !== 2'b10) begin errors++; $display("FAIL early_wlast_bresp: got %b want 10", b_resp); end
    checks++; if (mem[14'h100] !== 32'hA0 || mem[14'h101] !== 32'hA1)
      begin errors++; $display("FAIL early_wlast_mem: got %h %h want A0 A1", mem[14'h100], mem[14'h101]); end
    wd[0] = 32'hC0; wd[1] = 32'hC1;
    write_burst(32'h1000_FFFC, 4'd1, 8'h32, BURST_INCR, 1);
    checks++; if (b_resp !== 2'b00) begin errors++; $display("FAIL wrap_bresp: got %b want 00", b_resp); end
    checks++; if (mem[14'h3FFF] !== 32'hC0 || mem[14'h0000] !== 32'hC1)
      begin errors++; $display("FAIL wrap_mem: got %h %h want C0 C1", mem[14'h3FFF], mem[14'h0000]); end
    preload(14'h141, 32'h0);
    wd[0] = 32'hE0; wd[1] = 32'hE1;
    write_burst(32'h500, 4'd1, 8'h33, BURST_FIXED, 1);
    checks++; if (mem[14'h140] !== 32'hE1 || mem[14'h141] !== 32'h0)
      begin errors++; $display("FAIL fixed_mem: got %h %h want E1 0", mem[14'h140], mem[14'h141]); end
  endtask

  task automatic test_reset_mid_read();
    int n;
    for (int i = 0; i < 4; i++) preload(14'h20 + 14'(i), 32'h0B00_0000 + 32'(i));
    ARADDR = 32'h80; ARLEN = 4'd3; ARID = 8'h55; ARBURST = BURST_INCR; ARVALID = 1'b1; RREADY = 1'b1;
    #1;
    n = 0;
    while (!ARREADY && n < 20) begin tick(); n++; end
    tick();
    ARVALID = 1'b0;
    for (int b = 0; b < 2; b++) begin
      n = 0;
      while (!RVALID && n < 20) begin tick(); n++; end
      checks++; if (RDATA !== 32'h0B00_0000 + 32'(b))
        begin errors++; $display("FAIL midread_beat %0d: got %h want %h", b, RDATA, 32'h0B00_0000 + 32'(b)); end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    RREADY = 1'b0;
    #1;
    checks++; if (RVALID !== 1'b0) begin errors++; $display("FAIL midread_rvalid: got %0b want 0", RVALID); end
    ARVALID = 1'b1; ARADDR = 32'h84; ARLEN = 4'd0;
    #1;
    checks++; if (ARREADY !== 1'b1) begin errors++; $display("FAIL midread_arready: got %0b want 1", ARREADY); end
    ARVALID = 1'b0;
    #1;
    read_burst(32'h84, 4'd0, 8'h66, BURST_INCR);
    checks++; if (rd[0] !== 32'h0B00_0001 || rl[0] !== 1'b1 || rid_seen[0] !== 8'h66)
      begin errors++; $display("FAIL midread_new: data %h last %0b id %h want 0B000001 1 66", rd[0], rl[0], rid_seen[0]); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_write_read();
    test_strobe_backpressure();
    test_simultaneous();
    test_protocol_error_and_wrap();
    test_reset_mid_read();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
